div_issue_arbiter: RTL and testbench
====================================

# div_issue_arbiter

Shared front end for the iterative `divider`. Per-thread ALU lanes raise divide requests, and this block serves them one at a time. It picks a lane round-robin, latches that lane's operands, pulses the divider's `start`, waits for `done` under a watchdog, and returns the quotient to the requesting lane. Divide-by-zero is resolved locally and never reaches the divider.

## Interface
- `N`, 8: operand/result width; must match the divider's `N`.
- `LANES`, 4: number of requesting lanes; power of two, at least 2.
- `TIMEOUT`, 2*N+4: maximum number of WAIT cycles before the watchdog fires.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `req_valid`  in  LANES  per-lane divide request; held until accepted.
- `req_ready`  out  LANES  one-hot accept strobe; combinational, only in IDLE.
- `req_dividend`  in  LANES×N  per-lane dividend.
- `req_divisor`  in  LANES×N  per-lane divisor.
- `rsp_valid`  out  LANES  one-cycle, one-hot response pulse.
- `rsp_err`  out  1  qualifies `rsp_valid`: 1 = watchdog timeout.
- `rsp_result`  out  LANES×N  per-lane quotient; held until that lane's next response.
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_dividend`  out  N  latched operand, stable from ISSUE through WAIT.
- `div_divisor`  out  N  latched operand, stable from ISSUE through WAIT.
- `div_result`  in  N  divider quotient.
- `div_done`  in  1  divider completion (level).

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If any `req_valid` is high, grant lane g, the first requester at or after `rr_ptr` (wrapping).
  - Assert `req_ready[g]`; latch operands and g.
  - Divisor ≠ 0: go to ISSUE.
  - Divisor = 0: load result `{N{1'b1}}`, `err=0`, go to RESPOND.
- ISSUE:
  - `div_start=1` for this cycle only.
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - The first WAIT cycle ignores `div_done`, which may be stale-high from the previous op.
  - From the second WAIT cycle on, `div_done=1` captures `div_result`, sets `err=0`, and goes to RESPOND.
  - The counter increments every WAIT cycle. When it reaches `TIMEOUT` without done: result 0, `err=1`, go to RESPOND.
- RESPOND:
  - `rsp_valid[g]=1` for one cycle; `rsp_result[g]` updates; `rsp_err` = latched err.
  - `rr_ptr <= g+1`, mod LANES; go to IDLE.
- Only one divide is ever outstanding. Lanes other than g see `req_ready=0` until the FSM is back in IDLE.
- `req_valid` dropping after acceptance has no effect.
- Any lane re-requesting during a response is considered in the following IDLE cycle.
- Reset value of every output is 0: `req_ready`, `rsp_valid`, `rsp_err`, `rsp_result`, `div_start`, `div_dividend`, `div_divisor`.
- Reset also returns FSM=IDLE, `rr_ptr=0`, counter=0.
- Reset mid-operation aborts the divide with no response. A late `div_done` is ignored because the FSM is in IDLE.

## Timing
- Accept edge T, meaning `req_valid[g] & req_ready[g]` is high at the edge.
- Divisor ≠ 0:
  - `div_start` high during cycle T+1.
  - WAIT entered at T+2; `div_done` becomes eligible at T+3.
  - Done sampled high in cycle D gives `rsp_valid` in cycle D+1.
  - The next request can be accepted in cycle D+2.
- Divisor = 0: `rsp_valid` in cycle T+1; next accept in T+2.
- Timeout: `rsp_valid` with `rsp_err=1` in cycle T+2+TIMEOUT.
- Back-to-back service, one lane per transaction. The round-robin guarantees every requesting lane is served within LANES transactions.
- `rsp_err` is meaningful only while some `rsp_valid` bit is high; it is 0 otherwise.

## Structure
- Package `div_arb_pkg` holds:
  - the FSM state typedef `div_arb_state_t`;
  - the lane-index width `$clog2(LANES)`;
  - the divide-by-zero result constant.
- Sub-module `rr_arbiter`: combinational round-robin pick from `req_valid` and `rr_ptr`, returning a one-hot grant plus index. `rr_ptr` itself stays in this block.
- The divider is instantiated by the parent, not here. `div_*` connects port-for-port to `divider` `start`/`dividend`/`divisor`/`result`/`done`.

## Test plan
- Single divide: lane 0 requests 200/7; the model divider asserts done 10 cycles after start with result 28.
  - `div_start` pulses at T+1 with 200/7.
  - `rsp_valid=4'b0001` for one cycle; `rsp_result[0]=28`; `rsp_err=0`.
- Fairness: all four lanes request simultaneously after reset and hold `req_valid` → accept order 0,1,2,3,0; exactly one `rsp_valid` bit per transaction.
- Divide-by-zero: lane 2 requests 55/0.
  - No `div_start`.
  - `rsp_valid[2]` at T+1 with `rsp_result[2]=8'hFF`.
  - Lane 3 is granted next.
- Stale done: `div_done` is held high from before ISSUE, drops at T+3, and re-asserts at T+8 with result 12 → response at T+9 carrying 12. No early response.
- Timeout: the divider never asserts done → `rsp_valid` with `rsp_err=1` and result 0 in cycle T+2+TIMEOUT (T+22 for N=8); FSM back in IDLE.
- Reset in WAIT:
  - Drive `reset=0` mid-divide, release, then pulse `div_done`.
  - All outputs read 0 and no `rsp_valid` appears.
  - The next request from lane 1 is granted with `rr_ptr=0` semantics.

Source files
------------

// File: rtl/div_issue_arbiter_pkg.sv
// div_arb_pkg: shared types and constants for the divider issue arbiter.
//   div_arb_state_t : FSM state encoding (IDLE, ISSUE, WAIT, RESPOND)
//   lane_idx_w()    : width of a lane index for a given lane count
//   DBZ_RESULT      : quotient returned for divide-by-zero (all ones, truncated to N)
package div_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } div_arb_state_t;

    // Lane-index width; clamped to 1 so a degenerate lane count still elaborates.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // Wide all-ones constant; users truncate it to their operand width.
    localparam logic [63:0] DBZ_RESULT = '1;

endpackage

// File: rtl/div_issue_arbiter_if.sv
// div_issue_arbiter_if: lane request/response bundle plus the divider-side bus.
//   req_valid/req_ready/req_dividend/req_divisor : per-lane request handshake
//   rsp_valid/rsp_err/rsp_result                 : per-lane response
//   div_start/div_dividend/div_divisor           : to the shared divider
//   div_result/div_done                          : from the shared divider
// slave  = the arbiter's view; master = lanes + divider (environment) view.
interface div_issue_arbiter_if #(
    parameter int N     = 8,
    parameter int LANES = 4
);
    logic [LANES-1:0]        req_valid;
    logic [LANES-1:0]        req_ready;
    logic [LANES-1:0][N-1:0] req_dividend;
    logic [LANES-1:0][N-1:0] req_divisor;
    logic [LANES-1:0]        rsp_valid;
    logic                    rsp_err;
    logic [LANES-1:0][N-1:0] rsp_result;
    logic                    div_start;
    logic [N-1:0]            div_dividend;
    logic [N-1:0]            div_divisor;
    logic [N-1:0]            div_result;
    logic                    div_done;

    modport slave (
        input  req_valid, req_dividend, req_divisor, div_result, div_done,
        output req_ready, rsp_valid, rsp_err, rsp_result,
               div_start, div_dividend, div_divisor
    );

    modport master (
        output req_valid, req_dividend, req_divisor, div_result, div_done,
        input  req_ready, rsp_valid, rsp_err, rsp_result,
               div_start, div_dividend, div_divisor
    );

endinterface

// File: rtl/div_issue_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i  : per-lane request vector
//   ptr_i  : highest-priority lane this round
//   gnt_o  : one-hot grant (zero when nothing requests)
//   idx_o  : index of the granted lane
//   any_o  : some lane requested
// LANES must be a power of two so the index addition wraps on its own.
module rr_arbiter #(
    parameter int LANES = 4,
    parameter int IDX_W = 2
) (
    input  logic [LANES-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [LANES-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        // Walk lanes starting at ptr_i; the first hit wins.
        for (int i = 0; i < LANES; i++) begin
            cand = ptr_i + IDX_W'(i);
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
        if (any_o) gnt_o = LANES'(1) << idx_o;
    end

endmodule

// File: rtl/div_issue_arbiter.sv
// div_issue_arbiter: serialises per-lane divide requests onto one iterative
// divider. Round-robin grant, operand latch, one-cycle start pulse, watchdog
// on done, response routed back to the granted lane. Divide-by-zero is
// answered locally with all ones and never issued.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : lane request/response and divider handshake (slave view)
module div_issue_arbiter
    import div_arb_pkg::*;
#(
    parameter int N       = 8,
    parameter int LANES   = 4,
    parameter int TIMEOUT = 2*N+4
) (
    input logic              clk,
    input logic              reset,
    div_issue_arbiter_if.slave bus
);

    localparam int           IDX_W   = lane_idx_w(LANES);
    localparam int           CNT_W   = $clog2(TIMEOUT+1);
    localparam logic [N-1:0] DBZ_RES = N'(DBZ_RESULT);

    div_arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        gidx_q, gidx_d;
    logic [N-1:0]            dvd_q, dvd_d;
    logic [N-1:0]            dvs_q, dvs_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LANES-1:0][N-1:0] res_q, res_d;

    logic [LANES-1:0]        arb_gnt;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_any;

    rr_arbiter #(.LANES(LANES), .IDX_W(IDX_W)) u_rr (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    gidx_d = arb_idx;
                    dvd_d  = bus.req_dividend[arb_idx];
                    dvs_d  = bus.req_divisor[arb_idx];
                    if (bus.req_divisor[arb_idx] == '0) begin
                        // Result is written on the way into RESPOND so it is
                        // already visible while rsp_valid is high.
                        res_d[arb_idx] = DBZ_RES;
                        err_d          = 1'b0;
                        state_d        = S_RESPOND;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // cnt_q == 0 marks the first WAIT cycle, where done may still
                // be high from the previous operation.
                if (cnt_q != '0 && bus.div_done) begin
                    res_d[gidx_q] = bus.div_result;
                    err_d         = 1'b0;
                    state_d       = S_RESPOND;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    res_d[gidx_q] = '0;
                    err_d         = 1'b1;
                    state_d       = S_RESPOND;
                end
            end
            S_RESPOND: begin
                rr_ptr_d = gidx_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
        end
    end

    assign bus.req_ready    = (state_q == S_IDLE) ? arb_gnt : '0;
    assign bus.rsp_valid    = (state_q == S_RESPOND) ? (LANES'(1) << gidx_q) : '0;
    assign bus.rsp_err      = (state_q == S_RESPOND) && err_q;
    assign bus.rsp_result   = res_q;
    assign bus.div_start    = (state_q == S_ISSUE);
    assign bus.div_dividend = dvd_q;
    assign bus.div_divisor  = dvs_q;

endmodule

// File: tb/tb_div_issue_arbiter.sv
// tb_div_issue_arbiter: directed scenarios for div_issue_arbiter (N=8, LANES=4,
// TIMEOUT=20). Inputs change on the falling edge; outputs are sampled 1 time
// unit later, well away from the rising edge. The divider is played by the
// bench driving div_done/div_result cycle by cycle.
module tb_div_issue_arbiter;

    localparam int N       = 8;
    localparam int LANES   = 4;
    localparam int TIMEOUT = 2*N+4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    div_issue_arbiter_if #(.N(N), .LANES(LANES)) bus ();

    div_issue_arbiter #(.N(N), .LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic clear_inputs();
        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.div_result   = '0;
        bus.div_done     = 1'b0;
    endtask

    // Leaves the bench at a falling edge with reset released.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 4'b0 || bus.rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hs: ready=%b valid=%b err=%b want 0", bus.req_ready, bus.rsp_valid, bus.rsp_err);
        end
        n_cmp++;
        if (bus.rsp_result !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_result: got %h want 0", bus.rsp_result);
        end
        n_cmp++;
        if (bus.div_start !== 1'b0 || bus.div_dividend !== 8'h0 || bus.div_divisor !== 8'h0) begin
            n_bad++;
            $display("FAIL reset_div: start=%b dvd=%h dvs=%h want 0", bus.div_start, bus.div_dividend, bus.div_divisor);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single();
        bit early;
        do_reset();
        bus.req_valid       = 4'b0001;
        bus.req_dividend[0] = 8'd200;
        bus.req_divisor[0]  = 8'd7;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL single_grant: got %b want 0001", bus.req_ready);
        end
        @(negedge clk); // T+1
        bus.req_valid = '0;
        #1;
        n_cmp++;
        if (bus.div_start !== 1'b1 || bus.div_dividend !== 8'd200 || bus.div_divisor !== 8'd7) begin
            n_bad++;
            $display("FAIL single_issue: start=%b dvd=%0d dvs=%0d want 1/200/7", bus.div_start, bus.div_dividend, bus.div_divisor);
        end
        n_cmp++;
        if (bus.req_ready !== 4'b0) begin
            n_bad++;
            $display("FAIL single_busy_ready: got %b want 0000", bus.req_ready);
        end
        @(negedge clk); // T+2
        #1;
        n_cmp++;
        if (bus.div_start !== 1'b0) begin
            n_bad++;
            $display("FAIL single_start_pulse: got %b want 0", bus.div_start);
        end
        early = 1'b0;
        for (int c = 3; c <= 10; c++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid !== 4'b0) early = 1'b1;
        end
        @(negedge clk); // T+11: done 10 cycles after start
        bus.div_done   = 1'b1;
        bus.div_result = 8'd28;
        #1;
        if (bus.rsp_valid !== 4'b0) early = 1'b1;
        n_cmp++;
        if (early !== 1'b0) begin
            n_bad++;
            $display("FAIL single_early_rsp: got %b want 0", early);
        end
        @(negedge clk); // T+12
        bus.div_done = 1'b0;
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_result[0] !== 8'd28 || bus.rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL single_rsp: valid=%b res=%0d err=%b want 0001/28/0", bus.rsp_valid, bus.rsp_result[0], bus.rsp_err);
        end
        @(negedge clk); // T+13
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 4'b0 || bus.rsp_result[0] !== 8'd28) begin
            n_bad++;
            $display("FAIL single_rsp_pulse: valid=%b res=%0d want 0000/28", bus.rsp_valid, bus.rsp_result[0]);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_gnt;
        bit         found;
        do_reset();
        for (int l = 0; l < LANES; l++) begin
            bus.req_dividend[l] = 8'(50 + l);
            bus.req_divisor[l]  = 8'(3 + l);
        end
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            found   = 1'b0;
            for (int c = 0; c < 8; c++) begin
                #1;
                if (bus.req_ready !== 4'b0) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            n_cmp++;
            if (!found || bus.req_ready !== exp_gnt) begin
                n_bad++;
                $display("FAIL fair_grant%0d: got %b want %b", k, bus.req_ready, exp_gnt);
            end
            @(negedge clk); // T+1
            if (k == 4) bus.req_valid = '0;
            #1;
            n_cmp++;
            if (bus.div_start !== 1'b1 || bus.div_dividend !== 8'(50 + k % 4)) begin
                n_bad++;
                $display("FAIL fair_issue%0d: start=%b dvd=%0d want 1/%0d", k, bus.div_start, bus.div_dividend, 50 + k % 4);
            end
            @(negedge clk); // T+2 first WAIT
            @(negedge clk); // T+3
            bus.div_done   = 1'b1;
            bus.div_result = 8'(10 + k);
            @(negedge clk); // T+4
            bus.div_done = 1'b0;
            #1;
            n_cmp++;
            if (bus.rsp_valid !== exp_gnt || bus.rsp_result[k % 4] !== 8'(10 + k)) begin
                n_bad++;
                $display("FAIL fair_rsp%0d: valid=%b res=%0d want %b/%0d", k, bus.rsp_valid, bus.rsp_result[k % 4], exp_gnt, 10 + k);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div_by_zero();
        do_reset();
        bus.req_valid       = 4'b1100;
        bus.req_dividend[2] = 8'd55;
        bus.req_divisor[2]  = 8'd0;
        bus.req_dividend[3] = 8'd40;
        bus.req_divisor[3]  = 8'd5;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL dbz_grant: got %b want 0100", bus.req_ready);
        end
        @(negedge clk); // T+1
        bus.req_valid = 4'b1000;
        #1;
        n_cmp++;
        if (bus.div_start !== 1'b0) begin
            n_bad++;
            $display("FAIL dbz_no_start: got %b want 0", bus.div_start);
        end
        n_cmp++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_result[2] !== 8'hFF || bus.rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL dbz_rsp: valid=%b res=%h err=%b want 0100/ff/0", bus.rsp_valid, bus.rsp_result[2], bus.rsp_err);
        end
        @(negedge clk); // T+2
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b1000) begin
            n_bad++;
            $display("FAIL dbz_next_grant: got %b want 1000", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        n_cmp++;
        if (bus.div_start !== 1'b1 || bus.div_dividend !== 8'd40 || bus.div_divisor !== 8'd5) begin
            n_bad++;
            $display("FAIL dbz_lane3_issue: start=%b dvd=%0d dvs=%0d want 1/40/5", bus.div_start, bus.div_dividend, bus.div_divisor);
        end
        @(negedge clk);
        @(negedge clk);
        bus.div_done   = 1'b1;
        bus.div_result = 8'd8;
        @(negedge clk);
        bus.div_done = 1'b0;
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 4'b1000 || bus.rsp_result[3] !== 8'd8 || bus.rsp_result[2] !== 8'hFF) begin
            n_bad++;
            $display("FAIL dbz_lane3_rsp: valid=%b r3=%0d r2=%h want 1000/8/ff", bus.rsp_valid, bus.rsp_result[3], bus.rsp_result[2]);
        end
    endtask

    task automatic test_stale_done();
        bit early;
        do_reset();
        bus.div_done        = 1'b1;
        bus.div_result      = 8'd99;
        bus.req_valid       = 4'b0010;
        bus.req_dividend[1] = 8'd100;
        bus.req_divisor[1]  = 8'd8;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL stale_grant: got %b want 0010", bus.req_ready);
        end
        @(negedge clk); // T+1
        bus.req_valid = '0;
        @(negedge clk); // T+2 first WAIT, done still high
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 4'b0) begin
            n_bad++;
            $display("FAIL stale_wait1: got %b want 0000", bus.rsp_valid);
        end
        @(negedge clk); // T+3
        bus.div_done = 1'b0;
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 4'b0) begin
            n_bad++;
            $display("FAIL stale_ignored: got %b want 0000", bus.rsp_valid);
        end
        early = 1'b0;
        for (int c = 4; c <= 7; c++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid !== 4'b0) early = 1'b1;
        end
        @(negedge clk); // T+8
        bus.div_done   = 1'b1;
        bus.div_result = 8'd12;
        #1;
        if (bus.rsp_valid !== 4'b0) early = 1'b1;
        n_cmp++;
        if (early !== 1'b0) begin
            n_bad++;
            $display("FAIL stale_early: got %b want 0", early);
        end
        @(negedge clk); // T+9
        bus.div_done = 1'b0;
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_result[1] !== 8'd12 || bus.rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL stale_rsp: valid=%b res=%0d err=%b want 0010/12/0", bus.rsp_valid, bus.rsp_result[1], bus.rsp_err);
        end
    endtask

    // Runs straight after test_stale_done: lane 1 already holds 12, so a
    // timeout must visibly overwrite it with 0.
    task automatic test_timeout();
        bit early;
        @(negedge clk);
        bus.req_valid       = 4'b0010;
        bus.req_dividend[1] = 8'd9;
        bus.req_divisor[1]  = 8'd3;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL tmo_grant: got %b want 0010", bus.req_ready);
        end
        @(negedge clk); // T+1
        bus.req_valid = '0;
        #1;
        n_cmp++;
        if (bus.div_start !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_issue: got %b want 1", bus.div_start);
        end
        early = 1'b0;
        for (int c = 2; c <= 1 + TIMEOUT; c++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid !== 4'b0) early = 1'b1;
        end
        n_cmp++;
        if (early !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_early: got %b want 0", early);
        end
        @(negedge clk); // T+2+TIMEOUT
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_err !== 1'b1 || bus.rsp_result[1] !== 8'd0) begin
            n_bad++;
            $display("FAIL tmo_rsp: valid=%b err=%b res=%0d want 0010/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_result[1]);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 4'b0 || bus.rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_after: valid=%b err=%b want 0000/0", bus.rsp_valid, bus.rsp_err);
        end
    endtask

    // rr_ptr is 2 on entry; after the mid-divide reset lane 1 must beat lane 3.
    task automatic test_reset_in_wait();
        @(negedge clk);
        bus.req_valid       = 4'b0100;
        bus.req_dividend[2] = 8'd50;
        bus.req_divisor[2]  = 8'd5;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL rst_grant: got %b want 0100", bus.req_ready);
        end
        @(negedge clk); // T+1
        bus.req_valid = '0;
        @(negedge clk); // T+2
        @(negedge clk); // T+3, mid-WAIT
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 4'b0 || bus.rsp_err !== 1'b0 || bus.rsp_result !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_outputs: ready=%b valid=%b err=%b res=%h want 0", bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_result);
        end
        n_cmp++;
        if (bus.div_start !== 1'b0 || bus.div_dividend !== 8'h0 || bus.div_divisor !== 8'h0) begin
            n_bad++;
            $display("FAIL rst_div: start=%b dvd=%h dvs=%h want 0", bus.div_start, bus.div_dividend, bus.div_divisor);
        end
        @(negedge clk);
        reset          = 1'b1;
        bus.div_done   = 1'b1;
        bus.div_result = 8'd77;
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 4'b0) begin
            n_bad++;
            $display("FAIL rst_late_done0: got %b want 0000", bus.rsp_valid);
        end
        @(negedge clk);
        bus.div_done = 1'b0;
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 4'b0 || bus.div_start !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_late_done1: valid=%b start=%b want 0000/0", bus.rsp_valid, bus.div_start);
        end
        @(negedge clk);
        bus.req_valid       = 4'b1010;
        bus.req_dividend[1] = 8'd60;
        bus.req_divisor[1]  = 8'd6;
        bus.req_dividend[3] = 8'd70;
        bus.req_divisor[3]  = 8'd7;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL rst_ptr_grant: got %b want 0010", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        n_cmp++;
        if (bus.div_start !== 1'b1 || bus.div_dividend !== 8'd60) begin
            n_bad++;
            $display("FAIL rst_reissue: start=%b dvd=%0d want 1/60", bus.div_start, bus.div_dividend);
        end
        @(negedge clk);
        @(negedge clk);
        bus.div_done   = 1'b1;
        bus.div_result = 8'd10;
        @(negedge clk);
        bus.div_done = 1'b0;
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_result[1] !== 8'd10) begin
            n_bad++;
            $display("FAIL rst_rsp: valid=%b res=%0d want 0010/10", bus.rsp_valid, bus.rsp_result[1]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_div_by_zero();
        test_stale_done();
        test_timeout();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
